// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the byte-serial memory access controller.
//   - access size codes as carried on the size port
//   - controller FSM state encoding
//   - byte_count(): bytes moved per access size
//   - req_invalid(): reserved-size / misalignment rejection rule
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'b01;
  localparam logic [1:0] SZ_HALF = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [2:0] byte_count(input logic [1:0] size);
    case (size)
      SZ_WORD: byte_count = 3'd4;
      SZ_HALF: byte_count = 3'd2;
      default: byte_count = 3'd1;
    endcase
  endfunction

  function automatic logic req_invalid(input logic [1:0] size, input logic [1:0] addr_lo);
    req_invalid = (size == SZ_RSVD) ||
                  (size == SZ_WORD && addr_lo != 2'b00) ||
                  (size == SZ_HALF && addr_lo[0]);
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load data extension.
//   raw  : assembled load data, right-justified
//   size : access size code
//   sign : 1 = sign-extend byte/halfword, 0 = zero-extend
//   data : extended 32-bit result (word passes through)
module mem_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] data
);

  always_comb begin
    data = raw;
    case (size)
      SZ_BYTE: data = {{24{sign & raw[7]}}, raw[7:0]};
      SZ_HALF: data = {{16{sign & raw[15]}}, raw[15:0]};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Byte-serial memory access controller.
// Turns one word/halfword/byte pipeline request into N single-byte memory
// cycles, big-endian (MSB at lowest address), and assembles load data.
//   clk, reset          : clock, async active-high reset
//   req, rw, size, sign : request, direction (1=write), size code, load sign
//   addr, wdata         : byte address, right-justified store data
//   busy, done, err     : in-progress, completion pulse, rejection pulse
//   rdata               : last completed load result
//   mem_en, mem_rw, mem_addr, mem_wdata, mem_rdata : byte memory port
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_rw,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  state_t      state;
  logic        rw_r;
  logic        sign_r;
  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;
  logic [1:0]  k;        // current byte index
  logic [1:0]  last;     // N-1
  logic [1:0]  lane;     // buffer/data lane for byte k: N-1-k
  logic [31:0] asm_buf;
  logic [31:0] asm_next;
  logic [31:0] ext_data;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] ln);
    pick_byte = w[8*ln +: 8];
  endfunction

  // asm_next includes the byte arriving this cycle so the final load result
  // can be registered on the same edge that leaves XFER.
  always_comb begin
    lane     = last - k;
    asm_next = asm_buf;
    asm_next[8*lane +: 8] = mem_rdata;
  end

  mem_load_extend u_ext (
    .raw  (asm_next),
    .size (size_r),
    .sign (sign_r),
    .data (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rw_r      <= 1'b0;
      sign_r    <= 1'b0;
      size_r    <= '0;
      addr_r    <= '0;
      wdata_r   <= '0;
      k         <= '0;
      last      <= '0;
      asm_buf   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdata     <= '0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (req) begin
            rw_r    <= rw;
            size_r  <= size;
            sign_r  <= sign;
            addr_r  <= addr;
            wdata_r <= wdata;
            k       <= '0;
            last    <= 2'(byte_count(size) - 3'd1);
            asm_buf <= '0;
            busy    <= 1'b1;
            if (req_invalid(size, addr[1:0])) begin
              state <= RESP;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              // Memory outputs are registered, so byte 0 is presented here.
              state     <= XFER;
              mem_en    <= 1'b1;
              mem_rw    <= rw;
              mem_addr  <= addr;
              mem_wdata <= rw ? pick_byte(wdata, 2'(byte_count(size) - 3'd1)) : '0;
            end
          end
        end

        XFER: begin
          if (!rw_r) asm_buf <= asm_next;
          if (k == last) begin
            state     <= RESP;
            done      <= 1'b1;
            mem_en    <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if (!rw_r) rdata <= ext_data;
          end else begin
            k         <= k + 2'd1;
            mem_addr  <= addr_r + 32'(k) + 32'd1;
            mem_wdata <= rw_r ? pick_byte(wdata_r, lane - 2'd1) : '0;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a byte-array memory responder.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        rw;
  logic [1:0]  size;
  logic        sign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic        mem_en;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .rw        (rw),
    .size      (size),
    .sign      (sign),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .rdata     (rdata),
    .mem_en    (mem_en),
    .mem_rw    (mem_rw),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Byte memory responder: combinational read, write on the rising edge.
  logic [7:0]  mem [0:255];
  logic [31:0] wlog_a [$];
  logic [7:0]  wlog_d [$];
  logic [31:0] rlog_a [$];

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_en && mem_rw) begin
      mem[mem_addr[7:0]] <= mem_wdata;
      wlog_a.push_back(mem_addr);
      wlog_d.push_back(mem_wdata);
    end
    if (mem_en && !mem_rw) rlog_a.push_back(mem_addr);
  end

  int n_checks = 0;
  int n_fail   = 0;
  int lat, bcnt, ecnt, wb, rb, dcnt;
  logic        err_s;
  logic [31:0] rd_s;
  logic [7:0]  dmask, bmask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task cycle;
    @(posedge clk);
    #1;
  endtask

  // Issue one request and follow it until busy drops (bounded).
  // lat = sample index (1 = cycle after accept) where done was first seen.
  task run_req(input logic r, input logic [1:0] sz, input logic sg,
               input logic [31:0] a, input logic [31:0] wd);
    req = 1'b1; rw = r; size = sz; sign = sg; addr = a; wdata = wd;
    wb = wlog_a.size();
    rb = rlog_a.size();
    cycle();
    req = 1'b0;
    lat = 0; bcnt = 0; ecnt = 0; err_s = 1'b0; rd_s = '0;
    for (int i = 1; i <= 20; i++) begin
      if (busy) bcnt++;
      if (mem_en) ecnt++;
      if (done && lat == 0) begin
        lat   = i;
        err_s = err;
        rd_s  = rdata;
      end
      if (!busy) break;
      cycle();
    end
  endtask

  task chk_w(input string tag, input int idx, input logic [31:0] a, input logic [7:0] d);
    if (wb + idx < wlog_a.size()) begin
      check({tag, "_addr"}, wlog_a[wb + idx], a);
      check({tag, "_data"}, {24'h0, wlog_d[wb + idx]}, {24'h0, d});
    end else begin
      check({tag, "_present"}, wlog_a.size(), wb + idx + 1);
    end
  endtask

  task chk_r(input string tag, input int idx, input logic [31:0] a);
    if (rb + idx < rlog_a.size()) check({tag, "_raddr"}, rlog_a[rb + idx], a);
    else check({tag, "_rpresent"}, rlog_a.size(), rb + idx + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b [4];
    exp_b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    reset = 1'b1; req = 1'b0; rw = 1'b0; size = 2'b00; sign = 1'b0;
    addr = '0; wdata = '0;
    cycle(); cycle();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;

    // Word write 0xDEADBEEF at 0x10
    run_req(1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
    check("ww_lat", lat, 5);
    check("ww_busy", bcnt, 5);
    check("ww_en", ecnt, 4);
    check("ww_err", err_s, 0);
    check("ww_rdata", rd_s, 0);
    check("ww_nwr", wlog_a.size() - wb, 4);
    for (int i = 0; i < 4; i++) chk_w("ww", i, 32'h10 + i, exp_b[i]);

    // Word read back
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("wr_rdata", rd_s, 32'hDEADBEEF);
    check("wr_lat", lat, 5);
    check("wr_busy", bcnt, 5);
    for (int i = 0; i < 4; i++) chk_r("wr", i, 32'h10 + i);

    // Byte write 0x80 (upper wdata bits must be ignored), then signed/unsigned reads
    run_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h12345680);
    check("bw_lat", lat, 2);
    check("bw_nwr", wlog_a.size() - wb, 1);
    chk_w("bw", 0, 32'h20, 8'h80);
    run_req(1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
    check("br_s1", rd_s, 32'hFFFFFF80);
    check("br_lat", lat, 2);
    run_req(1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
    check("br_s0", rd_s, 32'h00000080);

    // Halfword 0x8001 at 0x30
    run_req(1'b1, 2'b10, 1'b0, 32'h30, 32'hAAAA8001);
    check("hw_lat", lat, 3);
    chk_w("hw0", 0, 32'h30, 8'h80);
    chk_w("hw1", 1, 32'h31, 8'h01);
    run_req(1'b0, 2'b10, 1'b1, 32'h30, 32'h0);
    check("hr_s1", rd_s, 32'hFFFF8001);
    run_req(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    check("hr_s0", rd_s, 32'h00008001);

    // Rejected requests: misaligned word, reserved size, misaligned halfword
    run_req(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    check("rj_w_en", ecnt, 0);
    check("rj_w_lat", lat, 1);
    check("rj_w_err", err_s, 1);
    check("rj_w_busy", bcnt, 1);
    check("rj_w_rdata", rd_s, 32'h00008001);
    run_req(1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
    check("rj_sz_en", ecnt, 0);
    check("rj_sz_lat", lat, 1);
    check("rj_sz_err", err_s, 1);
    check("rj_sz_rdata", rdata, 32'h00008001);
    run_req(1'b1, 2'b10, 1'b0, 32'h31, 32'h0);
    check("rj_h_err", err_s, 1);
    check("rj_h_nwr", wlog_a.size() - wb, 0);
    check("ok_err", 32'(err), 0);

    // Address wrap
    run_req(1'b1, 2'b01, 1'b0, 32'hFFFFFFFF, 32'h5A);
    chk_w("wrap_b", 0, 32'hFFFFFFFF, 8'h5A);
    run_req(1'b0, 2'b01, 1'b1, 32'hFFFFFFFF, 32'h0);
    check("wrap_br", rd_s, 32'h0000005A);
    check("wrap_br_err", err_s, 0);
    run_req(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hC3A5);
    chk_w("wrap_h0", 0, 32'hFFFFFFFE, 8'hC3);
    chk_w("wrap_h1", 1, 32'hFFFFFFFF, 8'hA5);
    run_req(1'b0, 2'b10, 1'b1, 32'hFFFFFFFE, 32'h0);
    check("wrap_hr", rd_s, 32'hFFFFC3A5);

    // Reset during XFER byte 2 of a word write
    wb = wlog_a.size();
    req = 1'b1; rw = 1'b1; size = 2'b00; sign = 1'b0; addr = 32'h40; wdata = 32'h11223344;
    cycle();
    req = 1'b0;
    cycle();
    cycle();
    check("ab_k2_addr", mem_addr, 32'h42);
    reset = 1'b1;
    #1;
    check("ab_busy", busy, 0);
    check("ab_mem_en", mem_en, 0);
    check("ab_mem_addr", mem_addr, 0);
    check("ab_mem_wdata", mem_wdata, 0);
    check("ab_rdata", rdata, 0);
    check("ab_nwr", wlog_a.size() - wb, 2);
    chk_w("ab0", 0, 32'h40, 8'h11);
    chk_w("ab1", 1, 32'h41, 8'h22);
    cycle();
    reset = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      cycle();
    end
    check("ab_nodone", dcnt, 0);
    check("ab_nwr_after", wlog_a.size() - wb, 2);
    run_req(1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    check("ab_next_lat", lat, 5);
    check("ab_next_rdata", rd_s, 32'hDEADBEEF);

    // req held high across two halfword reads
    rb = rlog_a.size();
    dmask = '0; bmask = '0;
    req = 1'b1; rw = 1'b0; size = 2'b10; sign = 1'b0; addr = 32'h30;
    cycle();
    for (int s = 1; s <= 8; s++) begin
      if (done) dmask[s-1] = 1'b1;
      if (busy) bmask[s-1] = 1'b1;
      if (s == 7) req = 1'b0;
      cycle();
    end
    check("b2b_done", dmask, 8'h44);
    check("b2b_busy", bmask, 8'h77);
    check("b2b_nrd", rlog_a.size() - rb, 4);
    chk_r("b2b0", 0, 32'h30);
    chk_r("b2b1", 1, 32'h31);
    chk_r("b2b2", 2, 32'h30);
    chk_r("b2b3", 3, 32'h31);
    check("b2b_rdata", rdata, 32'h00008001);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset: clk is the only clock, and reset is asynchronous and active-high.
REQ-002 The module SHALL have these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- req  in  1  pipeline access request
- rw  in  1  direction: 1 = write, 0 = read
- size  in  2  access size: 00 word, 01 byte, 10 halfword, 11 reserved
- sign  in  1  sign-extend on byte/halfword read
- addr  in  32  byte address of the access
- wdata  in  32  store data, right-justified for byte/halfword
- busy  out  1  request in progress; pipeline stalls on it
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, on a rejected request
- rdata  out  32  assembled load data
- mem_en  out  1  byte memory enable
- mem_rw  out  1  byte memory direction: 1 = write
- mem_addr  out  32  byte memory address
- mem_wdata  out  8  byte memory write data
- mem_rdata  in  8  byte memory read data, combinationally valid in the same cycle as mem_addr

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, XFER and RESP.
REQ-004 In IDLE, a request SHALL be accepted at the rising edge when req=1, and the controller SHALL register rw, size, sign, addr and wdata at that edge.
REQ-005 The byte count N SHALL be 4 for word, 2 for halfword and 1 for byte.
REQ-006 An accepted request with size=11, a word with addr[1:0]!=0, or a halfword with addr[0]!=0 SHALL go IDLE->RESP, issue no memory cycle, and leave rdata unchanged.
REQ-007 A valid accepted request SHALL go IDLE->XFER and spend exactly N cycles in XFER, with byte index k running 0..N-1.
REQ-008 In XFER cycle k the outputs SHALL be mem_en=1, mem_rw=rw and mem_addr=addr+k modulo 2^32.
REQ-009 Bytes SHALL be transferred big-endian, most-significant byte at the lowest address.
REQ-010 Write byte k SHALL be wdata[8(N-1-k)+7 : 8(N-1-k)].
REQ-011 On a read, mem_rdata in XFER cycle k SHALL be captured at that cycle's rising edge into assembly-buffer lane N-1-k.
REQ-012 After the last XFER cycle the FSM SHALL go XFER->RESP; RESP SHALL last one cycle, and then RESP->IDLE.
REQ-013 In RESP the outputs SHALL be done=1, and err=1 only for a request rejected under REQ-006.
REQ-014 rdata SHALL update on entering RESP after a read: a word is the 4 assembled bytes; a halfword or byte is zero-extended when sign=0 and sign-extended from bit 15 or bit 7 when sign=1.
REQ-015 rdata SHALL hold its value until the next completed read; writes and rejected requests leave it unchanged.
REQ-016 busy SHALL be 1 in XFER and RESP and 0 in IDLE; req SHALL be ignored while busy=1.
REQ-017 Outside XFER the outputs SHALL be mem_en=0, mem_rw=0, mem_addr=0 and mem_wdata=0.
REQ-018 Minimum request-to-request spacing SHALL be N+2 cycles (accept edge, N XFER cycles, RESP), so a back-to-back req can first be accepted in the IDLE cycle after RESP.
REQ-019 Address wrap SHALL be silent: a byte read at 0xFFFFFFFF is legal, and a halfword at 0xFFFFFFFE touches 0xFFFFFFFE and 0xFFFFFFFF.

Reset
REQ-020 Asserting reset at any time SHALL immediately force state to IDLE and set busy, done, err, mem_en, mem_rw, mem_addr, mem_wdata and rdata to 0.
REQ-021 A reset during XFER SHALL abort the access; bytes already written stay in memory, and no done is produced.
REQ-022 The first request SHALL be accepted at the first rising edge after reset deasserts, provided req=1.

Structure
REQ-023 The shared package SHALL hold the size codes (SZ_WORD=00, SZ_BYTE=01, SZ_HALF=10), the FSM state encoding, and the byte-count function.
REQ-024 Load extension SHALL be one combinational sub-module, mem_load_extend, with inputs raw 32-bit data, size and sign, and output 32-bit data.
REQ-025 Byte memory SHALL be modelled in the bench by a byte-array responder with a combinational read.

Verification
REQ-026 Word write addr=0x10, wdata=0xDEADBEEF -> 4 XFER cycles writing 0xDE,0xAD,0xBE,0xEF to addresses 0x10..0x13; done in cycle 5 after accept; rdata unchanged.
REQ-027 Word read addr=0x10 after the REQ-026 write -> rdata=0xDEADBEEF in the done cycle, busy=1 for exactly 5 cycles.
REQ-028 Byte read of 0x80 with sign=1 -> rdata=0xFFFFFF80; with sign=0 -> 0x00000080. Halfword 0x8001 with sign=1 -> 0xFFFF8001.
REQ-029 Word request at addr=0x12 and a request with size=11 -> mem_en never asserts; done=1 and err=1 in the cycle after accept; rdata unchanged.
REQ-030 Reset asserted during XFER cycle 2 of a word write -> all outputs 0 at once; only bytes 0..1 written; next req accepted cleanly.
REQ-031 req held high continuously across two halfword reads -> the second is accepted only in the IDLE cycle after RESP, with no byte dropped or duplicated.
